elevator_ctrl: RTL and testbench

//   Top-level sequencer for one elevator car. Owns the request queue registers (queue, tail) and

---
 rtl/elevator_ctrl.sv | 158 +++++++++++++++
 tb/tb_elevator_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: single-car sequencer owning the request queue, car position, motor and door.
// Optional feature macro DOOR_HOLD_EN adds a door_hold input that keeps the door open while high.
module elevator_ctrl #(
  parameter  int unsigned NUM_LVLS      = 4,
  parameter  int unsigned DEPTH         = 4,
  parameter  int unsigned TRAVEL_CYCLES = 8,
  parameter  int unsigned DOOR_CYCLES   = 6,
  parameter  int unsigned RESET_LVL     = 0,
  localparam int unsigned LVL_W         = $clog2(NUM_LVLS),
  localparam int unsigned TAIL_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pressed_en,
  input  logic [LVL_W-1:0]  pressed_lvl,
`ifdef DOOR_HOLD_EN
  input  logic              door_hold,
`endif
  output logic [LVL_W-1:0]  pos_lvl,
  output logic              dir_up,
  output logic              dir_dn,
  output logic              door_open,
  output logic              stop_at_pos_lvl,
  output logic [LVL_W-1:0]  head_lvl,
  output logic [TAIL_W-1:0] tail,
  output logic              queue_full,
  output logic              req_drop
);

  localparam int unsigned TRAV_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int unsigned DOOR_W = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MOVE, ARRIVE, DOOR} state_t;

  state_t              state_q;
  logic [LVL_W-1:0]    pos_lvl_q;
  logic                up_q, dn_q, door_q, stop_q, drop_q, full_q;
  logic [TRAV_W-1:0]   travel_cnt_q;
  logic [DOOR_W-1:0]   door_cnt_q;
  logic [LVL_W-1:0]    queue_q [DEPTH];
  logic [TAIL_W-1:0]   tail_q;

  logic [LVL_W-1:0]    queue_rm [DEPTH];
  logic [LVL_W-1:0]    queue_d  [DEPTH];
  logic [TAIL_W-1:0]   tail_rm, tail_d, rem_idx;
  logic                rem_hit, do_remove, dup, ignore, acceptable, append, drop_d, head_up;

  // Queue update: remove the serviced level first, then try to append the press.
  always_comb begin
    rem_hit = 1'b0;
    rem_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!rem_hit && TAIL_W'(i) < tail_q && queue_q[i] == pos_lvl_q) begin
        rem_hit = 1'b1;
        rem_idx = TAIL_W'(i);
      end
    end
    do_remove = ((state_q == IDLE) && (tail_q != '0) && (queue_q[0] == pos_lvl_q)) ||
                ((state_q == ARRIVE) && rem_hit);
    tail_rm = do_remove ? tail_q - TAIL_W'(1) : tail_q;

    for (int i = 0; i < int'(DEPTH); i++) queue_rm[i] = queue_q[i];
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (do_remove && TAIL_W'(i) >= rem_idx) queue_rm[i] = queue_q[i+1];
    end

    dup = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (TAIL_W'(i) < tail_rm && queue_rm[i] == pressed_lvl) dup = 1'b1;
    end
    ignore = dup || (32'(pressed_lvl) >= NUM_LVLS) ||
             (do_remove && pressed_lvl == pos_lvl_q) ||
             ((state_q == DOOR) && pressed_lvl == pos_lvl_q);
    acceptable = pressed_en && !ignore;
    append     = acceptable && (tail_rm != TAIL_W'(DEPTH));
    drop_d     = acceptable && (tail_rm == TAIL_W'(DEPTH));

    for (int i = 0; i < int'(DEPTH); i++) begin
      queue_d[i] = queue_rm[i];
      if (append && TAIL_W'(i) == tail_rm) queue_d[i] = pressed_lvl;
    end
    tail_d  = append ? tail_rm + TAIL_W'(1) : tail_rm;
    head_up = queue_q[0] > pos_lvl_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pos_lvl_q    <= LVL_W'(RESET_LVL);
      up_q         <= 1'b0;
      dn_q         <= 1'b0;
      door_q       <= 1'b0;
      stop_q       <= 1'b0;
      drop_q       <= 1'b0;
      full_q       <= 1'b0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
      tail_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) queue_q[i] <= '0;
    end else begin
      queue_q <= queue_d;
      tail_q  <= tail_d;
      full_q  <= (tail_d == TAIL_W'(DEPTH));
      drop_q  <= drop_d;
      stop_q  <= 1'b0;
      case (state_q)
        IDLE, ARRIVE: begin
          if (do_remove) begin
            stop_q     <= 1'b1;
            door_q     <= 1'b1;
            door_cnt_q <= DOOR_W'(DOOR_CYCLES - 1);
            state_q    <= DOOR;
          end else if (tail_q != '0) begin
            up_q         <= head_up;
            dn_q         <= !head_up;
            travel_cnt_q <= TRAV_W'(TRAVEL_CYCLES - 1);
            state_q      <= MOVE;
          end
        end
        MOVE: begin
          if (travel_cnt_q == '0) begin
            pos_lvl_q <= up_q ? pos_lvl_q + LVL_W'(1) : pos_lvl_q - LVL_W'(1);
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            state_q   <= ARRIVE;
          end else begin
            travel_cnt_q <= travel_cnt_q - TRAV_W'(1);
          end
        end
        DOOR: begin
`ifdef DOOR_HOLD_EN
          if (door_hold) begin
            door_cnt_q <= DOOR_W'(DOOR_CYCLES - 1);
          end else
`endif
          if (door_cnt_q == '0) begin
            door_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            door_cnt_q <= door_cnt_q - DOOR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pos_lvl         = pos_lvl_q;
  assign dir_up          = up_q;
  assign dir_dn          = dn_q;
  assign door_open       = door_q;
  assign stop_at_pos_lvl = stop_q;
  assign head_lvl        = queue_q[0];
  assign tail            = tail_q;
  assign queue_full      = full_q;
  assign req_drop        = drop_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed scenarios; a negedge monitor checks stop/drop events against a
// scoreboard plus travel and door durations.
module tb_elevator_ctrl;

  localparam int unsigned NL = 4;
  localparam int unsigned DP = 2;
  localparam int unsigned TC = 4;
  localparam int unsigned DC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       pressed_en;
  logic [1:0] pressed_lvl;
  logic       door_hold = 1'b0;
  logic [1:0] pos_lvl, head_lvl, tail;
  logic       dir_up, dir_dn, door_open, stop_at_pos_lvl, queue_full, req_drop;

  elevator_ctrl #(
    .NUM_LVLS(NL), .DEPTH(DP), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .RESET_LVL(0)
  ) dut (
    .clk(clk), .rst(rst), .pressed_en(pressed_en), .pressed_lvl(pressed_lvl),
`ifdef DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .pos_lvl(pos_lvl), .dir_up(dir_up), .dir_dn(dir_dn), .door_open(door_open),
    .stop_at_pos_lvl(stop_at_pos_lvl), .head_lvl(head_lvl), .tail(tail),
    .queue_full(queue_full), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  typedef struct { int pos; int tl; int head; } stop_t;
  typedef struct { int tl; int full; } drop_t;

  stop_t exp_stop[$];
  drop_t exp_drop[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_stop(input int p, input int t, input int h);
    stop_t s;
    s.pos = p; s.tl = t; s.head = h;
    exp_stop.push_back(s);
  endtask

  // Monitor: event scoreboard, travel segment length/step, door open length.
  int run_len = 0, run_start = 0, door_len = 0;
  bit run_up = 1'b0;
  always @(negedge clk) begin
    stop_t s;
    drop_t d;
    if (rst) begin
      run_len = 0;
      door_len = 0;
    end else begin
      chk("dir_exclusive", int'(dir_up & dir_dn), 0);
      if (stop_at_pos_lvl) begin
        if (exp_stop.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_stop actual pos %0d required none", int'(pos_lvl));
        end else begin
          s = exp_stop.pop_front();
          chk("stop_pos", int'(pos_lvl), s.pos);
          chk("stop_tail", int'(tail), s.tl);
          if (s.tl != 0) chk("stop_head", int'(head_lvl), s.head);
          chk("stop_door", int'(door_open), 1);
        end
      end
      if (req_drop) begin
        if (exp_drop.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_drop actual tail %0d required none", int'(tail));
        end else begin
          d = exp_drop.pop_front();
          chk("drop_tail", int'(tail), d.tl);
          chk("drop_full", int'(queue_full), d.full);
        end
      end
      if (dir_up || dir_dn) begin
        if (run_len == 0) begin
          run_start = int'(pos_lvl);
          run_up = dir_up;
        end
        run_len++;
      end else if (run_len != 0) begin
        chk("travel_len", run_len, int'(TC));
        chk("travel_step", int'(pos_lvl), run_up ? run_start + 1 : run_start - 1);
        run_len = 0;
      end
      if (door_open) door_len++;
      else if (door_len != 0) begin
        chk("door_len", door_len, int'(DC));
        door_len = 0;
      end
    end
  end

  task automatic press_n(input logic [1:0] lvl, input int n);
    pressed_en = 1'b1;
    pressed_lvl = lvl;
    repeat (n) begin
      @(posedge clk); #1;
    end
    pressed_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0, q = 0;
    while (q < 2 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (tail == 2'd0 && !door_open && !dir_up && !dir_dn) q++;
      else q = 0;
    end
    if (q < 2) begin
      checks++; errors++;
      $display("FAIL quiet_timeout actual tail %0d required idle within %0d cycles", int'(tail), budget);
    end
  endtask

  task automatic wait_pos(input int p, input bit need_up, input int budget);
    int n = 0;
    while (!(int'(pos_lvl) == p && (!need_up || dir_up)) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL pos_timeout actual %0d required %0d", int'(pos_lvl), p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    drop_t dr;
    rst = 1'b1;
    pressed_en = 1'b0;
    pressed_lvl = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pos", int'(pos_lvl), 0);
    chk("rst_tail", int'(tail), 0);
    chk("rst_up", int'(dir_up), 0);
    chk("rst_dn", int'(dir_dn), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_stop", int'(stop_at_pos_lvl), 0);
    chk("rst_drop", int'(req_drop), 0);
    chk("rst_full", int'(queue_full), 0);

    // Single trip 0 -> 2
    push_stop(2, 0, 0);
    press_n(2'd2, 1);
    wait_quiet(200);

    // Opportunistic stop at 1 on the way to 3
    do_reset();
    push_stop(1, 1, 3);
    push_stop(3, 0, 0);
    press_n(2'd3, 1);
    press_n(2'd1, 1);
    wait_quiet(300);

    // Duplicate press over two cycles while the queue is full is silently ignored
    do_reset();
    push_stop(2, 1, 3);
    push_stop(3, 0, 0);
    press_n(2'd3, 1);
    press_n(2'd2, 2);
    chk("dup_tail", int'(tail), 2);
    wait_quiet(300);

    // Third distinct press with DEPTH=2 is dropped
    do_reset();
    dr.tl = 2; dr.full = 1;
    exp_drop.push_back(dr);
    push_stop(2, 1, 3);
    push_stop(3, 0, 0);
    press_n(2'd3, 1);
    press_n(2'd2, 1);
    press_n(2'd1, 1);
    wait_quiet(300);

    // Press 2 in the ARRIVE cycle at 1 while removing 1: queue becomes {3,2}
    do_reset();
    push_stop(1, 2, 3);
    push_stop(2, 1, 3);
    push_stop(3, 0, 0);
    press_n(2'd3, 1);
    press_n(2'd1, 1);
    wait_pos(1, 1'b0, 50);
    press_n(2'd2, 1);
    wait_quiet(300);

    // Press at current level while idle opens the door; repeats at that level are ignored
    do_reset();
    push_stop(0, 0, 0);
    press_n(2'd0, 1);
    press_n(2'd0, 2);
    chk("same_lvl_tail", int'(tail), 0);
    wait_quiet(100);

    // Downward trip with intermediate stop: from 3 request 0 then 2
    push_stop(3, 0, 0);
    press_n(2'd3, 1);
    wait_quiet(300);
    push_stop(2, 1, 0);
    push_stop(0, 0, 0);
    press_n(2'd0, 1);
    press_n(2'd2, 1);
    wait_quiet(300);

    // Reset mid-move discards everything
    do_reset();
    press_n(2'd3, 1);
    wait_pos(1, 1'b1, 50);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pos", int'(pos_lvl), 0);
    chk("midrst_tail", int'(tail), 0);
    chk("midrst_up", int'(dir_up), 0);
    chk("midrst_dn", int'(dir_dn), 0);
    chk("midrst_door", int'(door_open), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_tail", int'(tail), 0);
    chk("post_rst_up", int'(dir_up), 0);

    chk("stop_queue_drained", exp_stop.size(), 0);
    chk("drop_queue_drained", exp_drop.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
